// File: rtl/alu_mux_pkg.sv
// Shared types for the registered ALU result selector.
// Optional macro ALU_RESULT_MUX_FLAGS_EN adds zero/neg flags to each entry.
package alu_mux_pkg;

    localparam int NUM_IN_DEF = 8;
    localparam int WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } buf_state_t;

    // Width-parametrised entry: entry_c#(W, S)::t
    virtual class entry_c #(
        parameter int W = WIDTH_DEF,
        parameter int S = 3
    );
        typedef struct packed {
            logic [W-1:0] data;
            logic [S-1:0] sel;
            logic         err;
`ifdef ALU_RESULT_MUX_FLAGS_EN
            logic         zero;
            logic         neg;
`endif
        } t;
    endclass

endpackage

// File: rtl/alu_result_mux_pipe_lane_select.sv
// Combinational N-to-1 lane selector; out-of-range opsel yields 0 and err.
// Ports: data_i (lane vector), opsel_i, data_o (selected lane), err_o.
module alu_result_mux_pipe_lane_select #(
    parameter int NUM_IN = 8,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        opsel_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    err_o
);

    always_comb begin
        data_o = '0;
        err_o  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(opsel_i) == k) begin
                data_o = data_i[k*WIDTH +: WIDTH];
                err_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_result_mux_pipe.sv
// Registered N-to-1 ALU result selector feeding a 2-entry skid buffer.
// Ports: clk, rst_n, in_* request side, out_* result side, out_count.
// Macro ALU_RESULT_MUX_FLAGS_EN adds out_zero / out_neg per entry.
module alu_result_mux_pipe
    import alu_mux_pkg::*;
#(
    parameter int  NUM_IN = NUM_IN_DEF,
    parameter int  WIDTH  = WIDTH_DEF,
    parameter int  CNT_W  = 16,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_opsel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
`ifdef ALU_RESULT_MUX_FLAGS_EN
    output logic                    out_zero,
    output logic                    out_neg,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        out_count
);

    typedef entry_c#(WIDTH, SEL_W)::t entry_t;

    buf_state_t       state_q;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           new_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             deliver;

    alu_result_mux_pipe_lane_select #(
        .NUM_IN(NUM_IN),
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_sel (
        .data_i (in_data),
        .opsel_i(in_opsel),
        .data_o (sel_data),
        .err_o  (sel_err)
    );

    // Ready/valid come from state only: no combinational in->ready path.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign cnt_d     = cnt_q + 1'b1;

    always_comb begin
        new_d      = '0;
        new_d.data = sel_data;
        new_d.sel  = in_opsel;
        new_d.err  = sel_err;
`ifdef ALU_RESULT_MUX_FLAGS_EN
        // Flags are stored per entry so they travel through the skid.
        new_d.zero = (sel_data == '0);
        new_d.neg  = sel_data[WIDTH-1];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (deliver) begin
                cnt_q <= cnt_d;
            end
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= new_d;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_q <= new_d;
                    end else if (accept) begin
                        skid_q  <= new_d;
                        state_q <= FULL;
                    end else if (deliver) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;
    assign out_err   = main_q.err;
    assign out_count = cnt_q;
`ifdef ALU_RESULT_MUX_FLAGS_EN
    assign out_zero  = main_q.zero;
    assign out_neg   = main_q.neg;
`endif

endmodule

// File: tb/tb_alu_result_mux_pipe.sv
// Directed self-checking bench for alu_result_mux_pipe.
// Three instances: 8 lanes, 5 lanes (err/flags), 4-bit counter (wrap).
module tb_alu_result_mux_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // 8-lane default instance
    logic [255:0] d8_data;
    logic [2:0]   d8_opsel;
    logic         d8_valid, d8_iready, d8_oready, d8_ovalid, d8_err;
    logic [31:0]  d8_odata;
    logic [2:0]   d8_osel;
    logic [15:0]  d8_cnt;

    // 5-lane instance
    logic [159:0] d5_data;
    logic [2:0]   d5_opsel;
    logic         d5_valid, d5_iready, d5_oready, d5_ovalid, d5_err;
    logic [31:0]  d5_odata;
    logic [2:0]   d5_osel;
    logic [15:0]  d5_cnt;

    // 4-bit counter instance
    logic [255:0] d4_data;
    logic [2:0]   d4_opsel;
    logic         d4_valid, d4_iready, d4_oready, d4_ovalid, d4_err;
    logic [31:0]  d4_odata;
    logic [2:0]   d4_osel;
    logic [3:0]   d4_cnt;

`ifdef ALU_RESULT_MUX_FLAGS_EN
    logic d8_zero, d8_neg, d5_zero, d5_neg, d4_zero, d4_neg;
`endif

    alu_result_mux_pipe #(.NUM_IN(8), .WIDTH(32), .CNT_W(16)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d8_data), .in_opsel(d8_opsel),
        .in_valid(d8_valid), .in_ready(d8_iready),
        .out_data(d8_odata), .out_sel(d8_osel), .out_err(d8_err),
`ifdef ALU_RESULT_MUX_FLAGS_EN
        .out_zero(d8_zero), .out_neg(d8_neg),
`endif
        .out_valid(d8_ovalid), .out_ready(d8_oready),
        .out_count(d8_cnt)
    );

    alu_result_mux_pipe #(.NUM_IN(5), .WIDTH(32), .CNT_W(16)) u5 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d5_data), .in_opsel(d5_opsel),
        .in_valid(d5_valid), .in_ready(d5_iready),
        .out_data(d5_odata), .out_sel(d5_osel), .out_err(d5_err),
`ifdef ALU_RESULT_MUX_FLAGS_EN
        .out_zero(d5_zero), .out_neg(d5_neg),
`endif
        .out_valid(d5_ovalid), .out_ready(d5_oready),
        .out_count(d5_cnt)
    );

    alu_result_mux_pipe #(.NUM_IN(8), .WIDTH(32), .CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d4_data), .in_opsel(d4_opsel),
        .in_valid(d4_valid), .in_ready(d4_iready),
        .out_data(d4_odata), .out_sel(d4_osel), .out_err(d4_err),
`ifdef ALU_RESULT_MUX_FLAGS_EN
        .out_zero(d4_zero), .out_neg(d4_neg),
`endif
        .out_valid(d4_ovalid), .out_ready(d4_oready),
        .out_count(d4_cnt)
    );

    task automatic test_reset();
        d8_data = '0; d8_opsel = '0; d8_valid = 0; d8_oready = 0;
        d5_data = '0; d5_opsel = '0; d5_valid = 0; d5_oready = 0;
        d4_data = '0; d4_opsel = '0; d4_valid = 0; d4_oready = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (d8_ovalid !== 1'b0 || d8_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_hold: valid=%b cnt=%0d want 0/0", d8_ovalid, d8_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (d8_iready !== 1'b1 || d8_ovalid !== 1'b0 || d8_odata !== 32'd0) begin
            fails++;
            $display("FAIL reset_release: rdy=%b valid=%b data=%h want 1/0/0",
                     d8_iready, d8_ovalid, d8_odata);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) d8_data[k*32 +: 32] = 32'h1000_0000 + k;
        d8_oready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d8_valid = 1'b1;
            d8_opsel = 3'(i);
            @(negedge clk);
            checks++;
            if (d8_ovalid !== 1'b1 || d8_odata !== 32'h1000_0000 + i ||
                d8_osel !== 3'(i) || d8_err !== 1'b0) begin
                fails++;
                $display("FAIL sweep_%0d: valid=%b data=%h sel=%0d err=%b want 1/%h/%0d/0",
                         i, d8_ovalid, d8_odata, d8_osel, d8_err, 32'h1000_0000 + i, i);
            end
        end
        d8_valid = 1'b0;
        d8_data  = 'x;
        @(negedge clk);
        checks++;
        if (d8_ovalid !== 1'b0 || d8_cnt !== 16'd8 || d8_odata !== 32'h1000_0007) begin
            fails++;
            $display("FAIL sweep_end: valid=%b cnt=%0d data=%h want 0/8/10000007",
                     d8_ovalid, d8_cnt, d8_odata);
        end
        for (int k = 0; k < 8; k++) d8_data[k*32 +: 32] = 32'h1000_0000 + k;
    endtask

    task automatic test_backpressure();
        d8_oready = 1'b0;
        d8_valid  = 1'b1;
        d8_opsel  = 3'd3;
        @(negedge clk);
        d8_opsel  = 3'd5;
        @(negedge clk);
        d8_valid  = 1'b0;
        checks++;
        if (d8_iready !== 1'b0 || d8_ovalid !== 1'b1 || d8_odata !== 32'h1000_0003) begin
            fails++;
            $display("FAIL bp_full: rdy=%b valid=%b data=%h want 0/1/10000003",
                     d8_iready, d8_ovalid, d8_odata);
        end
        @(negedge clk);
        checks++;
        if (d8_odata !== 32'h1000_0003 || d8_osel !== 3'd3 || d8_iready !== 1'b0) begin
            fails++;
            $display("FAIL bp_stable: data=%h sel=%0d rdy=%b want 10000003/3/0",
                     d8_odata, d8_osel, d8_iready);
        end
        d8_oready = 1'b1;
        @(negedge clk);
        checks++;
        if (d8_odata !== 32'h1000_0005 || d8_iready !== 1'b1 || d8_ovalid !== 1'b1) begin
            fails++;
            $display("FAIL bp_drain1: data=%h rdy=%b valid=%b want 10000005/1/1",
                     d8_odata, d8_iready, d8_ovalid);
        end
        @(negedge clk);
        checks++;
        if (d8_ovalid !== 1'b0 || d8_cnt !== 16'd10) begin
            fails++;
            $display("FAIL bp_drain2: valid=%b cnt=%0d want 0/10", d8_ovalid, d8_cnt);
        end
    endtask

    task automatic test_err_flags();
        logic [2:0]  ops   [5] = '{3'd6, 3'd2, 3'd0, 3'd4, 3'd5};
        logic [31:0] exp_d [5] = '{32'h0, 32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 32'h0};
        logic        exp_e [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ALU_RESULT_MUX_FLAGS_EN
        logic        exp_z [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        exp_n [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        d5_data[0*32 +: 32] = 32'h0000_0000;
        d5_data[1*32 +: 32] = 32'h1234_5678;
        d5_data[2*32 +: 32] = 32'h8000_0000;
        d5_data[3*32 +: 32] = 32'h0000_00A5;
        d5_data[4*32 +: 32] = 32'h7FFF_FFFF;
        d5_oready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d5_valid = 1'b1;
            d5_opsel = ops[i];
            @(negedge clk);
            checks++;
            if (d5_ovalid !== 1'b1 || d5_odata !== exp_d[i] ||
                d5_err !== exp_e[i] || d5_osel !== ops[i]) begin
                fails++;
                $display("FAIL lane5_op%0d: data=%h err=%b sel=%0d want %h/%b/%0d",
                         ops[i], d5_odata, d5_err, d5_osel, exp_d[i], exp_e[i], ops[i]);
            end
`ifdef ALU_RESULT_MUX_FLAGS_EN
            checks++;
            if (d5_zero !== exp_z[i] || d5_neg !== exp_n[i]) begin
                fails++;
                $display("FAIL flags_op%0d: zero=%b neg=%b want %b/%b",
                         ops[i], d5_zero, d5_neg, exp_z[i], exp_n[i]);
            end
`endif
        end
        d5_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        d8_oready = 1'b0;
        d8_valid  = 1'b1;
        d8_opsel  = 3'd6;
        @(negedge clk);
        d8_opsel  = 3'd2;
        @(negedge clk);
        d8_valid  = 1'b0;
        checks++;
        if (d8_iready !== 1'b0 || d8_cnt !== 16'd10) begin
            fails++;
            $display("FAIL ar_full: rdy=%b cnt=%0d want 0/10", d8_iready, d8_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (d8_ovalid !== 1'b0 || d8_cnt !== 16'd0 || d8_iready !== 1'b1) begin
            fails++;
            $display("FAIL ar_immediate: valid=%b cnt=%0d rdy=%b want 0/0/1",
                     d8_ovalid, d8_cnt, d8_iready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d8_oready = 1'b1;
        d8_valid  = 1'b1;
        d8_opsel  = 3'd1;
        @(negedge clk);
        d8_valid  = 1'b0;
        checks++;
        if (d8_ovalid !== 1'b1 || d8_odata !== 32'h1000_0001 || d8_osel !== 3'd1) begin
            fails++;
            $display("FAIL ar_after: valid=%b data=%h sel=%0d want 1/10000001/1",
                     d8_ovalid, d8_odata, d8_osel);
        end
        @(negedge clk);
        checks++;
        if (d8_ovalid !== 1'b0 || d8_cnt !== 16'd1) begin
            fails++;
            $display("FAIL ar_count: valid=%b cnt=%0d want 0/1", d8_ovalid, d8_cnt);
        end
    endtask

    task automatic test_count_wrap();
        for (int k = 0; k < 8; k++) d4_data[k*32 +: 32] = 32'hA0 + k;
        d4_oready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            d4_valid = 1'b1;
            d4_opsel = 3'(i % 8);
            @(negedge clk);
        end
        d4_valid = 1'b0;
        checks++;
        if (d4_cnt !== 4'd0 || d4_odata !== 32'hA0) begin
            fails++;
            $display("FAIL wrap_16: cnt=%0d data=%h want 0/a0", d4_cnt, d4_odata);
        end
        @(negedge clk);
        checks++;
        if (d4_cnt !== 4'd1 || d4_ovalid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_17: cnt=%0d valid=%b want 1/0", d4_cnt, d4_ovalid);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_err_flags();
        test_async_reset();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
